// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the hardwired zero register and the scoreboard per-register update kinds.
package reg_file_mp_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;

  typedef enum logic [1:0] {
    SB_HOLD,
    SB_SET,
    SB_CLR,
    SB_FLUSH
  } sb_op_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits with flush > alloc > write-clear precedence, plus a
// registered count of busy registers that always tracks the bit vector.
module reg_file_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_flush,
  output logic [2**ADDR_W-1:0]     o_busy,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // x0 is skipped entirely, so its bit keeps the reset value of 0.
  always_comb begin
    sb_op_e op;
    logic   wr_hit;
    op       = SB_HOLD;
    wr_hit   = 1'b0;
    busy_nxt = busy_q;
    cnt_nxt  = '0;
    for (int r = 1; r < DEPTH; r++) begin
      op     = SB_HOLD;
      wr_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && i_wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))
          wr_hit = 1'b1;
      end
      if (i_flush)
        op = SB_FLUSH;
      else if (i_alloc_en && i_alloc_addr == ADDR_W'(r))
        op = SB_SET;
      else if (wr_hit)
        op = SB_CLR;
      case (op)
        SB_SET:           busy_nxt[r] = 1'b1;
        SB_CLR, SB_FLUSH: busy_nxt[r] = 1'b0;
        default:          busy_nxt[r] = busy_q[r];
      endcase
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign o_busy     = busy_q;
  assign o_busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired x0, optional same-cycle write
// forwarding to reads, and a busy scoreboard for outstanding producers.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Ascending port loop: the last matching write scheduled wins, so the
  // highest enabled port index takes priority on an address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && i_wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
          mem[i_wr_addr[j*ADDR_W +: ADDR_W]] <= i_wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_flush      (i_flush),
    .o_busy       (busy),
    .o_busy_cnt   (o_busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    // Forwarding is suppressed while in reset so reads stay at zero.
    always_comb begin
      data = mem[addr];
      hit  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (BYPASS && i_rst_n && i_wr_en[j] &&
            i_wr_addr[j*ADDR_W +: ADDR_W] == addr) begin
          data = i_wr_data[j*DATA_W +: DATA_W];
          hit  = 1'b1;
        end
      end
      if (addr == ADDR_W'(ZERO_REG)) begin
        data = '0;
        hit  = 1'b0;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = data;
    assign o_rd_busy[k] = (addr != ADDR_W'(ZERO_REG)) && busy[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus randomized traffic against
// an array-based reference model of storage, forwarding and busy tracking.
module tb_reg_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam bit BYPASS = 1'b1;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR), .BYPASS (BYPASS)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_flush      (flush),
    .o_busy_cnt   (busy_cnt)
  );

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic int fwd_port(input int a);
    int p;
    p = -1;
    if (BYPASS && rst_n)
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && int'(wr_addr[j*ADDR_W +: ADDR_W]) == a) p = j;
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    int p;
    if (!rst_n || a == 0) return '0;
    p = fwd_port(a);
    if (p >= 0) return wr_data[p*DATA_W +: DATA_W];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!rst_n || a == 0) return 1'b0;
    if (fwd_port(a) >= 0) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [ADDR_W:0] exp_cnt();
    int s;
    s = 0;
    for (int r = 0; r < DEPTH; r++) s += int'(m_busy[r]);
    return (ADDR_W+1)'(s);
  endfunction

  task automatic model_edge();
    int a;
    for (int j = 0; j < NUM_WR; j++) begin
      a = int'(wr_addr[j*ADDR_W +: ADDR_W]);
      if (wr_en[j] && a != 0) begin
        m_mem[a]  = wr_data[j*DATA_W +: DATA_W];
        m_busy[a] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    if (flush) for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_in();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [DATA_W-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic do_alloc(input int a);
    alloc_en = 1'b1;
    alloc_addr = ADDR_W'(a);
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DEPTH-1));
    return int'($urandom_range(0, 7));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    rd_addr = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, a);
      set_rd(1, DEPTH-1-a);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        n_checks++;
        if (rd_data[k*DATA_W +: DATA_W] !== '0 || rd_busy[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read port%0d addr=%0d got data=%h busy=%b want 0/0",
                   k, rd_addr[k*ADDR_W +: ADDR_W], rd_data[k*DATA_W +: DATA_W], rd_busy[k]);
        end
      end
    end
    n_checks++;
    if (busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d want=0", busy_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    set_wr(0, 7, 32'hFEFE_EFEF);
    tick();
    clear_in();
    set_rd(0, 7);
    #1;
    n_checks++;
    if (rd_data[0 +: DATA_W] !== 32'hFEFE_EFEF) begin
      n_fail++;
      $display("FAIL write_read x7 got=%h want=fefeefef", rd_data[0 +: DATA_W]);
    end
    set_wr(0, 0, 32'hFFFF_FFFF);
    set_rd(0, 0);
    #1;
    n_checks++;
    if (rd_data[0 +: DATA_W] !== '0) begin
      n_fail++;
      $display("FAIL x0_bypass got=%h want=0", rd_data[0 +: DATA_W]);
    end
    tick();
    clear_in();
    #1;
    n_checks++;
    if (rd_data[0 +: DATA_W] !== '0) begin
      n_fail++;
      $display("FAIL x0_stored got=%h want=0", rd_data[0 +: DATA_W]);
    end
  endtask

  task automatic test_write_priority();
    set_wr(0, 5, 32'h1111_1111);
    set_wr(1, 5, 32'h2222_2222);
    set_rd(0, 5);
    #1;
    n_checks++;
    if (rd_data[0 +: DATA_W] !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL priority_bypass got=%h want=22222222", rd_data[0 +: DATA_W]);
    end
    tick();
    clear_in();
    #1;
    n_checks++;
    if (rd_data[0 +: DATA_W] !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL priority_stored got=%h want=22222222", rd_data[0 +: DATA_W]);
    end
  endtask

  task automatic test_scoreboard();
    do_alloc(3);
    tick();
    clear_in();
    set_rd(0, 3);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL alloc_x3 got busy=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
    end
    set_wr(0, 3, 32'hAB);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0 +: DATA_W] !== 32'hAB) begin
      n_fail++;
      $display("FAIL commit_x3_bypass got busy=%b data=%h want 0/ab", rd_busy[0], rd_data[0 +: DATA_W]);
    end
    tick();
    clear_in();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_x3_after got cnt=%0d busy=%b want 0/0", busy_cnt, rd_busy[0]);
    end
    do_alloc(4);
    set_wr(1, 4, 32'h55);
    tick();
    clear_in();
    set_rd(1, 4);
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || busy_cnt !== 6'd1 || rd_data[DATA_W +: DATA_W] !== 32'h55) begin
      n_fail++;
      $display("FAIL alloc_write_x4 got busy=%b cnt=%0d data=%h want 1/1/55",
               rd_busy[1], busy_cnt, rd_data[DATA_W +: DATA_W]);
    end
    set_wr(0, 4, 32'h66);
    tick();
    clear_in();
  endtask

  task automatic test_flush();
    do_alloc(1); tick();
    do_alloc(2); tick();
    do_alloc(9); tick();
    clear_in();
    set_rd(0, 9);
    #1;
    n_checks++;
    if (busy_cnt !== 6'd3 || rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre got cnt=%0d busy=%b want 3/1", busy_cnt, rd_busy[0]);
    end
    flush = 1'b1;
    do_alloc(6);
    set_wr(0, 8, 32'hCD);
    tick();
    clear_in();
    set_rd(1, 8);
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rd_data[DATA_W +: DATA_W] !== 32'hCD) begin
      n_fail++;
      $display("FAIL flush_post got cnt=%0d x8=%h want 0/cd", busy_cnt, rd_data[DATA_W +: DATA_W]);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, a);
      #1;
      n_checks++;
      if (rd_busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_busy x%0d got=%b want=0", a, rd_busy[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ed;
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int j = 0; j < NUM_WR; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, rand_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) do_alloc(rand_addr());
      flush = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < NUM_RD; k++) set_rd(k, rand_addr());
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        ed = exp_data(int'(rd_addr[k*ADDR_W +: ADDR_W]));
        n_checks++;
        if (rd_data[k*DATA_W +: DATA_W] !== ed) begin
          n_fail++;
          $display("FAIL rand_data cyc=%0d port%0d addr=%0d got=%h want=%h", c, k,
                   rd_addr[k*ADDR_W +: ADDR_W], rd_data[k*DATA_W +: DATA_W], ed);
        end
        n_checks++;
        if (rd_busy[k] !== exp_busy(int'(rd_addr[k*ADDR_W +: ADDR_W]))) begin
          n_fail++;
          $display("FAIL rand_busy cyc=%0d port%0d addr=%0d got=%b want=%b", c, k,
                   rd_addr[k*ADDR_W +: ADDR_W], rd_busy[k],
                   exp_busy(int'(rd_addr[k*ADDR_W +: ADDR_W])));
        end
      end
      n_checks++;
      if (busy_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, busy_cnt, exp_cnt());
      end
      tick();
    end
    clear_in();
  endtask

  task automatic test_async_reset();
    set_wr(0, 2, 32'hA5A5_0002);
    set_wr(1, 3, 32'h5A5A_0003);
    flush = 1'b1;
    tick();
    clear_in();
    do_alloc(2); tick();
    do_alloc(3); tick();
    clear_in();
    set_rd(0, 2);
    set_rd(1, 3);
    #1;
    n_checks++;
    if (busy_cnt !== 6'd2 || rd_data[0 +: DATA_W] !== 32'hA5A5_0002) begin
      n_fail++;
      $display("FAIL areset_pre got cnt=%0d x2=%h want 2/a5a50002", busy_cnt, rd_data[0 +: DATA_W]);
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    set_wr(0, 5, 32'h77);
    do_alloc(5);
    #1;
    n_checks++;
    if (rd_data !== '0 || busy_cnt !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate got data=%h cnt=%0d busy=%b want 0/0/0", rd_data, busy_cnt, rd_busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL areset_edge_cnt got=%0d want=0", busy_cnt);
    end
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    set_rd(0, 5);
    set_rd(1, 2);
    #1;
    n_checks++;
    if (rd_data !== '0 || busy_cnt !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL areset_lost_commit got data=%h cnt=%0d busy=%b want 0/0/0", rd_data, busy_cnt, rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_priority();
    test_scoreboard();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
